// File: rtl/memlibc_memory_bist_scheduler.sv
// Runs the scheduled MBIST controllers one at a time and summarises their results.
// Optional watchdog enabled by defining MEMLIBC_MBIST_SCHED_WATCHDOG_EN.
module memlibc_memory_bist_scheduler #(
    parameter int unsigned NUM_CTRL   = 4,
    parameter int unsigned TIMEOUT_W  = 16,
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned IDX_W      = (NUM_CTRL > 1) ? $clog2(NUM_CTRL) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [NUM_CTRL-1:0]  ctrl_mask_i,
    input  logic [TIMEOUT_W-1:0] timeout_i,
    input  logic [NUM_CTRL-1:0]  ctrl_done_i,
    input  logic [NUM_CTRL-1:0]  ctrl_go_i,
    output logic [NUM_CTRL-1:0]  ctrl_en_o,
    output logic [IDX_W-1:0]     cur_idx_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic [NUM_CTRL-1:0]  fail_o,
    output logic [NUM_CTRL-1:0]  timeout_o,
    output logic                 aborted_o
);
    // Scan pointer must be able to point one past the last controller.
    localparam int unsigned SCAN_W = $clog2(NUM_CTRL + 1);
    localparam int unsigned SET_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_RUN, S_SETTLE, S_DONE} state_e;

    state_e              state_q, state_d;
    logic [NUM_CTRL-1:0] mask_q, mask_d;
    logic [SCAN_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]    cur_idx_q, cur_idx_d;
    logic [NUM_CTRL-1:0] en_q, en_d;
    logic [NUM_CTRL-1:0] fail_q, fail_d;
    logic [SET_W-1:0]    settle_q, settle_d;
    logic                aborted_q, aborted_d;
    logic                pass_q, pass_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [IDX_W-1:0]    sel_idx;
    logic                sel_found;
    logic                abort_now;
`ifdef MEMLIBC_MBIST_SCHED_WATCHDOG_EN
    logic [TIMEOUT_W-1:0] timer_q, timer_d;
    logic [NUM_CTRL-1:0]  timeout_q, timeout_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^timeout_i;
`endif

    // Lowest scheduled controller at or above the scan pointer.
    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int i = int'(NUM_CTRL) - 1; i >= 0; i--) begin
            if (mask_q[i] && (i >= int'(idx_q))) begin
                sel_idx   = IDX_W'(i);
                sel_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        idx_d     = idx_q;
        cur_idx_d = cur_idx_q;
        en_d      = en_q;
        fail_d    = fail_q;
        settle_d  = settle_q;
        aborted_d = aborted_q;
        pass_d    = pass_q;
`ifdef MEMLIBC_MBIST_SCHED_WATCHDOG_EN
        timer_d   = timer_q;
        timeout_d = timeout_q;
`endif
        abort_now = abort_i && (state_q inside {S_SCAN, S_RUN, S_SETTLE});

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    mask_d    = ctrl_mask_i;
                    fail_d    = '0;
                    aborted_d = 1'b0;
                    pass_d    = 1'b0;
                    idx_d     = '0;
`ifdef MEMLIBC_MBIST_SCHED_WATCHDOG_EN
                    timeout_d = '0;
`endif
                    state_d   = S_SCAN;
                end
            end
            S_SCAN: begin
                if (sel_found) begin
                    cur_idx_d = sel_idx;
                    en_d      = NUM_CTRL'(1) << sel_idx;
`ifdef MEMLIBC_MBIST_SCHED_WATCHDOG_EN
                    timer_d   = '0;
`endif
                    state_d   = S_RUN;
                end else begin
                    pass_d  = ~|fail_q & ~aborted_q;
                    state_d = S_DONE;
                end
            end
            S_RUN: begin
                // A done seen on the expiry cycle takes priority over the watchdog.
                if (ctrl_done_i[cur_idx_q]) begin
                    fail_d[cur_idx_q] = ~ctrl_go_i[cur_idx_q];
                    en_d              = '0;
                    settle_d          = '0;
                    state_d           = S_SETTLE;
                end
`ifdef MEMLIBC_MBIST_SCHED_WATCHDOG_EN
                else if ((timeout_i != '0) && (timer_q == timeout_i - TIMEOUT_W'(1))) begin
                    timeout_d[cur_idx_q] = 1'b1;
                    fail_d[cur_idx_q]    = 1'b1;
                    en_d                 = '0;
                    settle_d             = '0;
                    state_d              = S_SETTLE;
                end else begin
                    timer_d = timer_q + TIMEOUT_W'(1);
                end
`endif
            end
            S_SETTLE: begin
                if (settle_q == SET_W'(SETTLE_CYC - 1)) begin
                    idx_d   = SCAN_W'(cur_idx_q) + SCAN_W'(1);
                    state_d = S_SCAN;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort discards any result sampled on the same edge.
        if (abort_now) begin
            en_d      = '0;
            fail_d    = fail_q;
            aborted_d = 1'b1;
            pass_d    = 1'b0;
`ifdef MEMLIBC_MBIST_SCHED_WATCHDOG_EN
            timeout_d = timeout_q;
`endif
            state_d   = S_DONE;
        end

        busy_d = state_d inside {S_SCAN, S_RUN, S_SETTLE};
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            mask_q    <= '0;
            idx_q     <= '0;
            cur_idx_q <= '0;
            en_q      <= '0;
            fail_q    <= '0;
            settle_q  <= '0;
            aborted_q <= 1'b0;
            pass_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef MEMLIBC_MBIST_SCHED_WATCHDOG_EN
            timer_q   <= '0;
            timeout_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            idx_q     <= idx_d;
            cur_idx_q <= cur_idx_d;
            en_q      <= en_d;
            fail_q    <= fail_d;
            settle_q  <= settle_d;
            aborted_q <= aborted_d;
            pass_q    <= pass_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef MEMLIBC_MBIST_SCHED_WATCHDOG_EN
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign ctrl_en_o = en_q;
    assign cur_idx_o = cur_idx_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign pass_o    = pass_q;
    assign fail_o    = fail_q;
    assign aborted_o = aborted_q;
`ifdef MEMLIBC_MBIST_SCHED_WATCHDOG_EN
    assign timeout_o = timeout_q;
`else
    assign timeout_o = '0;
`endif

endmodule

// File: tb/tb_memlibc_memory_bist_scheduler.sv
// Scoreboard bench for memlibc_memory_bist_scheduler with behavioural BIST controllers.
module tb_memlibc_memory_bist_scheduler;
    localparam int N  = 4;
    localparam int SC = 2;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          start_i = 1'b0;
    logic          abort_i = 1'b0;
    logic [N-1:0]  ctrl_mask_i = '0;
    logic [15:0]   timeout_i = '0;
    logic [N-1:0]  ctrl_done_i = '0;
    logic [N-1:0]  ctrl_go_i = '0;
    logic [N-1:0]  ctrl_en_o;
    logic [1:0]    cur_idx_o;
    logic          busy_o;
    logic          done_o;
    logic          pass_o;
    logic [N-1:0]  fail_o;
    logic [N-1:0]  timeout_o;
    logic          aborted_o;

    memlibc_memory_bist_scheduler #(
        .NUM_CTRL(N), .TIMEOUT_W(16), .SETTLE_CYC(SC)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
        .ctrl_mask_i(ctrl_mask_i), .timeout_i(timeout_i),
        .ctrl_done_i(ctrl_done_i), .ctrl_go_i(ctrl_go_i),
        .ctrl_en_o(ctrl_en_o), .cur_idx_o(cur_idx_o), .busy_o(busy_o),
        .done_o(done_o), .pass_o(pass_o), .fail_o(fail_o),
        .timeout_o(timeout_o), .aborted_o(aborted_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit           is_done;
        logic [N-1:0] en;
        logic [1:0]   idx;
        int           gap;
        logic         pass;
        logic [N-1:0] fail;
        logic [N-1:0] tmo;
        logic         ab;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_en(input logic [N-1:0] en, input logic [1:0] idx, input int gap);
        ev_t e;
        e = '{is_done: 1'b0, en: en, idx: idx, gap: gap, pass: 1'b0, fail: '0, tmo: '0, ab: 1'b0};
        exp_q.push_back(e);
    endtask

    task automatic push_done(input logic pass, input logic [N-1:0] fail, input logic [N-1:0] tmo,
                             input logic ab, input int gap);
        ev_t e;
        e = '{is_done: 1'b1, en: '0, idx: '0, gap: gap, pass: pass, fail: fail, tmo: tmo, ab: ab};
        exp_q.push_back(e);
    endtask

    // Behavioural controllers: done (with go) after dly enabled cycles unless hung.
    int dly[N];
    bit hang[N];
    bit go_cfg[N];
    int cnt[N];

    always @(negedge clk_i) begin
        for (int i = 0; i < N; i++) begin
            if (ctrl_en_o[i]) begin
                cnt[i]++;
                if (!hang[i] && cnt[i] >= dly[i]) begin
                    ctrl_done_i[i] = 1'b1;
                    ctrl_go_i[i]   = go_cfg[i];
                end
            end else begin
                cnt[i]         = 0;
                ctrl_done_i[i] = 1'b0;
                ctrl_go_i[i]   = 1'b0;
            end
        end
    end

    task automatic set_ctrl(input int i, input int d, input bit g, input bit h);
        dly[i] = d; go_cfg[i] = g; hang[i] = h;
    endtask

    // Monitor: pops an expectation at every enable rise and every done rise.
    logic [N-1:0] prev_en = '0;
    logic         prev_done = 1'b0;
    int           low_cnt = 0;
    int           hi_cnt = 0;
    int           hi_len[N];
    ev_t          me;

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            prev_en = '0; prev_done = 1'b0; low_cnt = 0; hi_cnt = 0;
        end else begin
            if (ctrl_en_o != '0 && prev_en == '0) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_enable actual=%b expected=none", ctrl_en_o);
                end else begin
                    me = exp_q.pop_front();
                    chk("event_kind_en", 32'(1'b0), 32'(me.is_done));
                    chk("enable_onehot", 32'(ctrl_en_o), 32'(me.en));
                    chk("cur_idx", 32'(cur_idx_o), 32'(me.idx));
                    if (me.gap >= 0) chk("settle_gap", low_cnt, me.gap);
                end
            end
            if (ctrl_en_o == '0 && prev_en != '0) hi_len[cur_idx_o] = hi_cnt;
            if (done_o && !prev_done) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done actual=1 expected=none");
                end else begin
                    me = exp_q.pop_front();
                    chk("event_kind_done", 32'(1'b1), 32'(me.is_done));
                    chk("pass", 32'(pass_o), 32'(me.pass));
                    chk("fail_vec", 32'(fail_o), 32'(me.fail));
                    chk("timeout_vec", 32'(timeout_o), 32'(me.tmo));
                    chk("aborted", 32'(aborted_o), 32'(me.ab));
                    chk("en_low_at_done", 32'(ctrl_en_o), 32'(0));
                    if (me.gap >= 0) chk("done_gap", low_cnt, me.gap);
                end
            end
            if (ctrl_en_o == '0) begin low_cnt++; hi_cnt = 0; end
            else begin hi_cnt++; low_cnt = 0; end
            prev_en   = ctrl_en_o;
            prev_done = done_o;
        end
    end

    task automatic do_start(input logic [N-1:0] m);
        @(negedge clk_i);
        ctrl_mask_i = m;
        start_i     = 1'b1;
        @(negedge clk_i);
        start_i     = 1'b0;
        ctrl_mask_i = ~m;
        chk("busy_after_start", 32'(busy_o), 32'(1));
    endtask

    task automatic wait_en(input logic [N-1:0] v, input string name);
        int n = 0;
        while (ctrl_en_o !== v && n < 300) begin @(negedge clk_i); n++; end
        chk(name, 32'(ctrl_en_o), 32'(v));
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done_o !== 1'b1 && n < 2000) begin @(negedge clk_i); n++; end
        chk(name, 32'(done_o), 32'(1));
        repeat (2) @(negedge clk_i);
    endtask

    initial begin
        for (int i = 0; i < N; i++) set_ctrl(i, 10, 1'b1, 1'b0);
        #2;
        chk("rst_en", 32'(ctrl_en_o), 32'(0));
        chk("rst_busy", 32'(busy_o), 32'(0));
        chk("rst_done", 32'(done_o), 32'(0));
        chk("rst_pass", 32'(pass_o), 32'(0));
        chk("rst_idx", 32'(cur_idx_o), 32'(0));
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);

        // Sparse mask, all pass.
        push_en(4'b0001, 2'd0, -1);
        push_en(4'b0010, 2'd1, SC + 1);
        push_en(4'b1000, 2'd3, SC + 1);
        push_done(1'b1, 4'b0000, 4'b0000, 1'b0, SC + 1);
        do_start(4'b1011);
        chk("en_after_start", 32'(ctrl_en_o), 32'(0));
        @(negedge clk_i);
        chk("en_one_after", 32'(ctrl_en_o), 32'(4'b0001));
        wait_done("done_sparse");
        chk("en_len_ctrl3", hi_len[3], 10);

        // Controller 2 fails, controller 3 still runs.
        set_ctrl(2, 10, 1'b0, 1'b0);
        push_en(4'b0001, 2'd0, -1);
        push_en(4'b0010, 2'd1, SC + 1);
        push_en(4'b0100, 2'd2, SC + 1);
        push_en(4'b1000, 2'd3, SC + 1);
        push_done(1'b0, 4'b0100, 4'b0000, 1'b0, SC + 1);
        do_start(4'b1111);
        wait_done("done_fail2");
        set_ctrl(2, 10, 1'b1, 1'b0);

`ifdef MEMLIBC_MBIST_SCHED_WATCHDOG_EN
        // Ctrl 1 hangs; ctrl 2 finishes on the expiry cycle so done wins.
        timeout_i = 16'd8;
        set_ctrl(0, 3, 1'b1, 1'b0);
        set_ctrl(1, 10, 1'b1, 1'b1);
        set_ctrl(2, 8, 1'b1, 1'b0);
        push_en(4'b0001, 2'd0, -1);
        push_en(4'b0010, 2'd1, SC + 1);
        push_en(4'b0100, 2'd2, SC + 1);
        push_done(1'b0, 4'b0010, 4'b0010, 1'b0, SC + 1);
        do_start(4'b0111);
        wait_done("done_watchdog");
        chk("wd_en_len_ctrl1", hi_len[1], 8);
        chk("wd_en_len_ctrl2", hi_len[2], 8);
`else
        // Without the watchdog timeout_i has no effect.
        timeout_i = 16'd3;
        push_en(4'b0001, 2'd0, -1);
        push_en(4'b0010, 2'd1, SC + 1);
        push_done(1'b1, 4'b0000, 4'b0000, 1'b0, SC + 1);
        do_start(4'b0011);
        wait_done("done_nowd");
        chk("nowd_en_len_ctrl0", hi_len[0], 10);
`endif
        timeout_i = '0;
        for (int i = 0; i < N; i++) set_ctrl(i, 10, 1'b1, 1'b0);

        // Abort during ctrl 1; a start while busy is ignored.
        set_ctrl(1, 10, 1'b1, 1'b1);
        push_en(4'b0001, 2'd0, -1);
        push_en(4'b0010, 2'd1, SC + 1);
        push_done(1'b0, 4'b0000, 4'b0000, 1'b1, -1);
        do_start(4'b1111);
        start_i = 1'b1; ctrl_mask_i = '0;
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        chk("start_while_busy", 32'(busy_o), 32'(1));
        wait_en(4'b0010, "wait_en_ctrl1");
        repeat (2) @(negedge clk_i);
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        chk("abort_en_low", 32'(ctrl_en_o), 32'(0));
        chk("abort_done", 32'(done_o), 32'(1));
        chk("abort_flag", 32'(aborted_o), 32'(1));
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        @(negedge clk_i);
        chk("abort_in_done_hold", 32'(done_o), 32'(1));
        set_ctrl(1, 10, 1'b1, 1'b0);

        // Empty mask after abort: results cleared, pass one cycle after scan.
        push_done(1'b1, 4'b0000, 4'b0000, 1'b0, -1);
        do_start(4'b0000);
        chk("empty_done_low", 32'(done_o), 32'(0));
        @(negedge clk_i);
        chk("empty_done_high", 32'(done_o), 32'(1));
        chk("empty_pass", 32'(pass_o), 32'(1));
        repeat (2) @(negedge clk_i);

        // Asynchronous reset mid-run.
        push_en(4'b0001, 2'd0, -1);
        do_start(4'b1111);
        wait_en(4'b0001, "wait_en_ctrl0");
        repeat (3) @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_en", 32'(ctrl_en_o), 32'(0));
        chk("arst_busy", 32'(busy_o), 32'(0));
        chk("arst_done", 32'(done_o), 32'(0));
        chk("arst_fail", 32'(fail_o), 32'(0));
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        @(negedge clk_i);
        chk("idle_abort_busy", 32'(busy_o), 32'(0));
        chk("idle_abort_done", 32'(done_o), 32'(0));
        chk("idle_abort_flag", 32'(aborted_o), 32'(0));

        repeat (3) @(negedge clk_i);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL global_timeout actual=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "global timeout");
    end

endmodule
